// File: rtl/aes_inv_key_schedule_if.sv
// aes_inv_key_schedule_if
// Bundles the request/response signals of the AES-128 inverse key schedule.
//   master: drives start, key_last and key_ready; observes the key stream.
//   slave : the key schedule itself; drives busy, key_valid, key_out,
//           round_out and done.
// Clock and reset stay as plain ports on the modules.
interface aes_inv_key_schedule_if;
    logic         start;
    logic [127:0] key_last;
    logic         key_ready;
    logic         busy;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         done;

    modport master (
        output start, key_last, key_ready,
        input  busy, key_valid, key_out, round_out, done
    );

    modport slave (
        input  start, key_last, key_ready,
        output busy, key_valid, key_out, round_out, done
    );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule
// AES-128 inverse key schedule. Given the round-10 key, streams the round keys
// 10, 9, ..., 0 with a valid/ready handshake, one key per cycle when the
// consumer holds key_ready high.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : aes_inv_key_schedule_if.slave
//            start/key_last   - begin a run from the round-10 key (IDLE only)
//            key_valid/ready  - key_out/round_out handshake
//            busy             - high outside IDLE
//            done             - one-cycle pulse after the round-0 key is taken
module aes_inv_key_schedule (
    input  logic                   clk,
    input  logic                   rst,
    aes_inv_key_schedule_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    // Forward AES S-box, entry 0x00 in the most-significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'd2047 - {b, 3'b000};
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Rcon of the round being undone; round 0 never steps, so it maps to 0.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       state, state_nxt;
    logic [127:0] key_q;
    logic [3:0]   rnd_q;
    logic         done_q;
    logic         hs;
    logic         last_hs;

    // Reverse step: undo the XOR chain first, then w0 needs the already
    // recovered w3 of the previous round.
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  w0p, w1p, w2p, w3p;
    logic [127:0] key_prev;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign w3p = w3 ^ w2;
    assign w2p = w2 ^ w1;
    assign w1p = w1 ^ w0;
    assign w0p = w0 ^ sub_word({w3p[23:0], w3p[31:24]}) ^ {rcon(rnd_q), 24'h0};
    assign key_prev = {w0p, w1p, w2p, w3p};

    assign hs      = (state == EMIT) && bus.key_ready;
    assign last_hs = hs && (rnd_q == 4'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = EMIT;
            EMIT:    if (last_hs)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.key_valid = (state == EMIT);
        bus.key_out   = key_q;
        bus.round_out = rnd_q;
        bus.done      = done_q;
    end

    // Key/round datapath. key_q is left untouched after round 0 so the last
    // key remains visible once the run is over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            rnd_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_hs;
            if ((state == IDLE) && bus.start) begin
                key_q <= bus.key_last;
                rnd_q <= 4'd10;
            end else if (hs && (rnd_q != 4'd0)) begin
                key_q <= key_prev;
                rnd_q <= rnd_q - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule
// Scoreboard bench: each scenario pushes the expected round keys when it
// starts a run and pops/compares them on every handshake. Reference keys are
// the FIPS-197 appendix A.1 expansion of 2b7e1516...
module tb_aes_inv_key_schedule;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        bit           chk;
    } exp_t;

    logic clk;
    logic rst;
    aes_inv_key_schedule_if bus ();

    aes_inv_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] fips [0:10];
    localparam logic [127:0] ZK_LAST = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic push_fips;
        for (int r = 10; r >= 0; r--) sb.push_back(exp_t'{4'(r), fips[r], 1'b1});
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.key_last = '0; bus.key_ready = 1'b0;
        #2;
        n_tests++;
        if ({bus.busy, bus.key_valid, bus.done, bus.round_out} !== 7'd0 || bus.key_out !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_state got busy=%b valid=%b done=%b rnd=%0d key=%h exp all 0",
                     bus.busy, bus.key_valid, bus.done, bus.round_out, bus.key_out);
        end
        @(negedge clk); rst = 1'b0;
        bus.key_ready = 1'b1;    // ready with nothing valid must do nothing
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.key_valid, bus.done, bus.round_out} !== 7'd0 || bus.key_out !== 128'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset got busy=%b valid=%b done=%b rnd=%0d exp idle zeros",
                     bus.busy, bus.key_valid, bus.done, bus.round_out);
        end
    endtask

    task automatic test_full_run;
        exp_t e;
        int   cyc;
        sb.delete(); push_fips();
        @(negedge clk);
        bus.key_last = fips[10]; bus.start = 1'b1; bus.key_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            n_tests++;
            if (bus.key_valid !== 1'b1 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL full_run_valid cyc=%0d got valid=%b busy=%b exp 1", cyc, bus.key_valid, bus.busy);
            end else begin
                e = sb.pop_front();
                if (bus.round_out !== e.rnd || bus.key_out !== e.key) begin
                    n_fail++;
                    $display("FAIL full_run_key got r%0d %h exp r%0d %h", bus.round_out, bus.key_out, e.rnd, e.key);
                end
            end
            @(negedge clk); cyc++;
        end
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL full_run_timeout left=%0d exp 0", sb.size()); end
        n_tests++;
        if ({bus.done, bus.key_valid, bus.busy} !== 3'b100 || bus.key_out !== fips[0] || bus.round_out !== 4'd0) begin
            n_fail++;
            $display("FAIL full_run_done got done=%b valid=%b busy=%b rnd=%0d key=%h exp 1/0/0 r0 %h",
                     bus.done, bus.key_valid, bus.busy, bus.round_out, bus.key_out, fips[0]);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0 || bus.key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse got done=%b valid=%b exp 0/0", bus.done, bus.key_valid);
        end
    endtask

    task automatic test_backpressure;
        exp_t         e;
        int           cyc;
        logic         stalled;
        logic [127:0] sk;
        logic [3:0]   sr;
        sb.delete(); push_fips();
        @(negedge clk);
        bus.key_last = fips[10]; bus.start = 1'b1; bus.key_ready = 1'b0;
        @(negedge clk); bus.start = 1'b0;
        stalled = 1'b0; sk = '0; sr = '0; cyc = 0;
        while (sb.size() != 0 && cyc < 400) begin
            if (stalled) begin
                n_tests++;
                if (bus.key_valid !== 1'b1 || bus.key_out !== sk || bus.round_out !== sr) begin
                    n_fail++;
                    $display("FAIL stall_hold got v=%b r%0d %h exp v=1 r%0d %h", bus.key_valid, bus.round_out, bus.key_out, sr, sk);
                end
            end
            if (bus.key_valid === 1'b1) begin
                bus.key_ready = 1'($urandom_range(0, 1));
                if (bus.key_ready) begin
                    e = sb.pop_front();
                    n_tests++;
                    if (bus.round_out !== e.rnd || bus.key_out !== e.key) begin
                        n_fail++;
                        $display("FAIL bp_key got r%0d %h exp r%0d %h", bus.round_out, bus.key_out, e.rnd, e.key);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1; sk = bus.key_out; sr = bus.round_out;
                end
            end
            @(negedge clk); cyc++;
        end
        n_tests++;
        if (sb.size() != 0 || bus.done !== 1'b1 || bus.key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end got left=%0d done=%b valid=%b exp 0/1/0", sb.size(), bus.done, bus.key_valid);
        end
    endtask

    task automatic test_zero_key;
        exp_t e;
        int   cyc;
        sb.delete();
        sb.push_back(exp_t'{4'd10, ZK_LAST, 1'b1});
        for (int r = 9; r >= 1; r--) sb.push_back(exp_t'{4'(r), 128'd0, 1'b0});
        sb.push_back(exp_t'{4'd0, 128'd0, 1'b1});
        @(negedge clk);
        bus.key_last = ZK_LAST; bus.start = 1'b1; bus.key_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            if (bus.key_valid === 1'b1) begin
                e = sb.pop_front();
                n_tests++;
                if (bus.round_out !== e.rnd || (e.chk && bus.key_out !== e.key)) begin
                    n_fail++;
                    $display("FAIL zero_key got r%0d %h exp r%0d %h", bus.round_out, bus.key_out, e.rnd, e.key);
                end
            end
            @(negedge clk); cyc++;
        end
        n_tests++;
        if (sb.size() != 0 || bus.done !== 1'b1 || bus.key_out !== 128'd0) begin
            n_fail++;
            $display("FAIL zero_key_end got left=%0d done=%b key=%h exp 0/1/0", sb.size(), bus.done, bus.key_out);
        end
    endtask

    task automatic test_start_busy;
        exp_t e;
        int   cyc;
        sb.delete(); push_fips();
        @(negedge clk);
        bus.key_last = fips[10]; bus.start = 1'b1; bus.key_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            bus.start = 1'b0;
            if (bus.key_valid === 1'b1) begin
                if (bus.round_out === 4'd7) begin
                    bus.start = 1'b1; bus.key_last = 128'h0123456789abcdeffedcba9876543210;
                end
                e = sb.pop_front();
                n_tests++;
                if (bus.round_out !== e.rnd || bus.key_out !== e.key) begin
                    n_fail++;
                    $display("FAIL start_busy_key got r%0d %h exp r%0d %h", bus.round_out, bus.key_out, e.rnd, e.key);
                end
            end
            @(negedge clk); cyc++;
        end
        bus.start = 1'b0;
        n_tests++;
        if (sb.size() != 0 || bus.done !== 1'b1 || bus.key_out !== fips[0]) begin
            n_fail++;
            $display("FAIL start_busy_end got left=%0d done=%b key=%h exp 0/1/%h", sb.size(), bus.done, bus.key_out, fips[0]);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        @(negedge clk);
        bus.key_last = fips[10]; bus.start = 1'b1; bus.key_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        cyc = 0;
        while (!(bus.key_valid === 1'b1 && bus.round_out === 4'd5) && cyc < 20) begin
            @(negedge clk); cyc++;
        end
        n_tests++;
        if (bus.round_out !== 4'd5 || bus.key_out !== fips[5]) begin
            n_fail++;
            $display("FAIL reset_mid_reach got r%0d %h exp r5 %h", bus.round_out, bus.key_out, fips[5]);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.busy, bus.key_valid, bus.done, bus.round_out} !== 7'd0 || bus.key_out !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async got busy=%b valid=%b done=%b rnd=%0d key=%h exp all 0",
                     bus.busy, bus.key_valid, bus.done, bus.round_out, bus.key_out);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle got busy=%b valid=%b exp 0/0", bus.busy, bus.key_valid);
        end
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        n_tests++;
        if (bus.key_valid !== 1'b1 || bus.round_out !== 4'd10 || bus.key_out !== fips[10]) begin
            n_fail++;
            $display("FAIL reset_mid_restart got v=%b r%0d %h exp v=1 r10 %h", bus.key_valid, bus.round_out, bus.key_out, fips[10]);
        end
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 30) begin
            @(negedge clk); cyc++;
        end
        n_tests++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL reset_mid_drain got done=%b exp 1", bus.done); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc;
        logic chk_next;
        sb.delete(); push_fips(); push_fips();
        @(negedge clk);
        bus.key_last = fips[10]; bus.start = 1'b1; bus.key_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        chk_next = 1'b0; cyc = 0;
        while (sb.size() != 0 && cyc < 60) begin
            if (chk_next) begin
                n_tests++;
                if (bus.key_valid !== 1'b1 || bus.round_out !== 4'd10) begin
                    n_fail++;
                    $display("FAIL b2b_restart got v=%b r%0d exp v=1 r10", bus.key_valid, bus.round_out);
                end
                chk_next = 1'b0;
            end
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                bus.start = 1'b1; bus.key_last = fips[10]; chk_next = 1'b1;
            end
            if (bus.key_valid === 1'b1) begin
                e = sb.pop_front();
                n_tests++;
                if (bus.round_out !== e.rnd || bus.key_out !== e.key) begin
                    n_fail++;
                    $display("FAIL b2b_key got r%0d %h exp r%0d %h", bus.round_out, bus.key_out, e.rnd, e.key);
                end
            end
            @(negedge clk); cyc++;
        end
        bus.start = 1'b0;
        n_tests++;
        if (sb.size() != 0 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end got left=%0d done=%b exp 0/1", sb.size(), bus.done);
        end
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle got busy=%b done=%b exp 0/0", bus.busy, bus.done);
        end
    endtask

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        test_reset();
        test_full_run();
        test_backpressure();
        test_zero_key();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
